// File: rtl/global_defs.sv
// Shared definitions for the trace-parser / memory-controller path.
// parsed_op_t      : opcode produced by the trace parser (NOP = no request)
// ADDRESS_WIDTH    : width of a parsed request address
// queue_entry_t    : one buffered request in the request queue
// QUEUE_DEPTH      : default number of request-queue entries
package global_defs;

    localparam int ADDRESS_WIDTH   = 40;
    localparam int QUEUE_DEPTH     = 16;
    localparam int QUEUE_AGE_WIDTH = 8;

    typedef enum logic [1:0] {
        DATA_READ  = 2'd0,
        DATA_WRITE = 2'd1,
        IFETCH     = 2'd2,
        NOP        = 2'd3
    } parsed_op_t;

    typedef struct packed {
        parsed_op_t                   op;
        logic [ADDRESS_WIDTH-1:0]     addr;
        logic [QUEUE_AGE_WIDTH-1:0]   age;
    } queue_entry_t;

endpackage

// File: rtl/request_queue_age_counter.sv
// Saturating per-entry age counter.
// Ports:
//   clk, rst_n  : clock, async active-low reset (age -> 0)
//   clr_i       : slot is being dequeued, age -> 0
//   load_zero_i : slot is being written, age -> 0
//   en_i        : slot is occupied, count up by one
//   age_o       : current age, saturates at all-ones
module age_counter #(
    parameter int AGE_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 load_zero_i,
    input  logic                 en_i,
    output logic [AGE_WIDTH-1:0] age_o
);

    logic [AGE_WIDTH-1:0] age_q;
    logic [AGE_WIDTH-1:0] age_d;

    always_comb begin
        age_d = age_q;
        if (clr_i || load_zero_i) begin
            age_d = '0;
        end else if (en_i && (age_q != {AGE_WIDTH{1'b1}})) begin
            age_d = age_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    assign age_o = age_q;

endmodule

// File: rtl/request_queue.sv
// Request queue: buffers non-NOP parser requests in arrival order for the
// memory-controller scheduler. Circular FIFO with occupancy count, per-entry
// saturating age and a sticky overflow flag.
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   in_opcode, in_address   : request from parser (NOP = nothing)
//   in_ready                : queue not full
//   out_valid, out_ready    : head handshake with scheduler
//   out_opcode/address/age  : head entry (NOP/0/0 when empty)
//   count                   : occupancy
//   overflow                : sticky, a request was dropped while full
module request_queue
    import global_defs::*;
#(
    parameter int DEPTH     = QUEUE_DEPTH,
    parameter int AGE_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  parsed_op_t                 in_opcode,
    input  logic [ADDRESS_WIDTH-1:0]   in_address,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output parsed_op_t                 out_opcode,
    output logic [ADDRESS_WIDTH-1:0]   out_address,
    output logic [AGE_WIDTH-1:0]       out_age,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0]              head_q, head_d;
    logic [PW-1:0]              tail_q, tail_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       overflow_q, overflow_d;
    parsed_op_t                 op_q   [DEPTH];
    logic [ADDRESS_WIDTH-1:0]   addr_q [DEPTH];
    logic [AGE_WIDTH-1:0]       age_w  [DEPTH];

    logic enq;
    logic deq;
    logic req;

    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign req       = (in_opcode != NOP);
    assign enq       = req && in_ready;
    assign deq       = out_valid && out_ready;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (enq) begin
            tail_d = tail_q + 1'b1;
        end
        if (deq) begin
            head_d = head_q + 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // in_ready is from the pre-edge count, so a same-cycle pop never saves it
        if (req && !in_ready) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]   <= NOP;
                addr_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (enq) begin
                op_q[tail_q]   <= in_opcode;
                addr_q[tail_q] <= in_address;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        logic [PW-1:0] rel;
        logic          occupied;

        // slot is live when its distance from head is below the occupancy
        assign rel      = PW'(g) - head_q;
        assign occupied = ({1'b0, rel} < count_q);

        age_counter #(.AGE_WIDTH(AGE_WIDTH)) u_age (
            .clk         (clk),
            .rst_n       (rst_n),
            .clr_i       (deq && (head_q == PW'(g))),
            .load_zero_i (enq && (tail_q == PW'(g))),
            .en_i        (occupied),
            .age_o       (age_w[g])
        );
    end

    assign out_opcode  = out_valid ? op_q[head_q]   : NOP;
    assign out_address = out_valid ? addr_q[head_q] : '0;
    assign out_age     = out_valid ? age_w[head_q]  : '0;
    assign count       = count_q;
    assign overflow    = overflow_q;

endmodule
